// File: rtl/fft_frame_reader.sv
// Frame buffer behind the streaming FFT: checks sink framing and ping-pongs
// whole frames, then plays them out in natural order with round/saturate.
// Ports: clk, aclr_n (async active-low reset);
//   sink_sop/eop/valid, sink_Re/Im : framed FFT result input, no backpressure
//   source_ready                   : downstream accepts the current sample
//   source_sop/eop/valid/Re/Im     : scaled natural-order output stream
//   overflow                       : current output sample saturated
//   error                          : one-cycle pulse per framing fault/overrun
module fft_frame_reader #(
  parameter int POW       = 9,
  parameter int IN_WIDTH  = 41,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 9,
  parameter int BITREV    = 1
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 sink_sop,
  input  logic                 sink_eop,
  input  logic                 sink_valid,
  input  logic [IN_WIDTH-1:0]  sink_Re,
  input  logic [IN_WIDTH-1:0]  sink_Im,
  input  logic                 source_ready,
  output logic                 source_sop,
  output logic                 source_eop,
  output logic                 source_valid,
  output logic [OUT_WIDTH-1:0] source_Re,
  output logic [OUT_WIDTH-1:0] source_Im,
  output logic                 overflow,
  output logic                 error
);

  localparam int N  = 1 << POW;
  localparam int IW = IN_WIDTH;
  localparam int OW = OUT_WIDTH;

  typedef logic [POW-1:0] idx_t;
  localparam idx_t LAST = idx_t'(N - 1);

  localparam logic signed [IW:0] RND =
    (SHIFT > 0) ? ((IW+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [IW:0] MAXV =
    {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] MINV =
    {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_SEND} rstate_t;

  logic [2*IW-1:0] mem [2*N];

  wstate_t    wstate;
  idx_t       wcnt;
  idx_t       dcnt;
  logic       wb;
  rstate_t    rstate;
  idx_t       rcnt;
  logic       rb;
  logic [1:0] full;

  logic          wr_en;
  logic [POW:0]  wr_addr;
  logic          fill_done;
  logic          xfer;
  logic          take;
  logic          nxt_ok;
  logic          nxt_bank;
  idx_t          nxt_idx;
  idx_t          rd_idx;
  logic [2*IW-1:0] rd_word;
  logic [OW:0]   sc_re;
  logic [OW:0]   sc_im;
  logic [1:0]    set_m;
  logic [1:0]    clr_m;

  function automatic idx_t brev(input idx_t a);
    idx_t r;
    for (int i = 0; i < POW; i++) r[i] = a[POW-1-i];
    return r;
  endfunction

  // Returns {saturated, value}.
  function automatic logic [OW:0] scale(input logic [IW-1:0] x);
    logic signed [IW:0] e;
    logic signed [IW:0] y;
    e = $signed({x[IW-1], x}) + RND;
    y = e >>> SHIFT;
    if (y > MAXV)      scale = {1'b1, MAXV[OW-1:0]};
    else if (y < MINV) scale = {1'b1, MINV[OW-1:0]};
    else               scale = {1'b0, y[OW-1:0]};
  endfunction

  always_comb begin
    wr_en = sink_valid &&
      ((wstate == W_IDLE && sink_sop && !full[wb]) ||
       wstate == W_FILL);
    wr_addr = {wb, sink_sop ? idx_t'(0) : wcnt};
    fill_done = sink_valid && wstate == W_FILL &&
      !sink_sop && sink_eop && wcnt == LAST;
  end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= {sink_Re, sink_Im};

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wstate <= W_IDLE;
      wcnt   <= '0;
      dcnt   <= '0;
      wb     <= 1'b0;
      error  <= 1'b0;
    end else begin
      error <= 1'b0;
      if (sink_valid) begin
        unique case (wstate)
          W_IDLE: begin
            if (sink_sop) begin
              if (full[wb]) begin
                error  <= 1'b1;
                dcnt   <= idx_t'(1);
                wstate <= sink_eop ? W_IDLE : W_DROP;
              end else if (sink_eop) begin
                error <= 1'b1;
              end else begin
                wcnt   <= idx_t'(1);
                wstate <= W_FILL;
              end
            end
          end
          W_FILL: begin
            if (sink_sop) begin
              // restart the frame at address 0
              error <= 1'b1;
              wcnt  <= idx_t'(1);
              if (sink_eop) wstate <= W_IDLE;
            end else if (wcnt == LAST) begin
              wstate <= W_IDLE;
              if (sink_eop) wb <= ~wb;
              else          error <= 1'b1;
            end else if (sink_eop) begin
              error  <= 1'b1;
              wstate <= W_IDLE;
            end else begin
              wcnt <= wcnt + idx_t'(1);
            end
          end
          W_DROP: begin
            if (sink_eop || dcnt == LAST) wstate <= W_IDLE;
            else dcnt <= dcnt + idx_t'(1);
          end
          default: wstate <= W_IDLE;
        endcase
      end
    end
  end

  assign source_valid = (rstate == R_SEND);
  assign xfer = source_valid && source_ready;
  assign take = !source_valid || source_ready;

  // Pick the sample to load into the output register at the next edge;
  // at the end of a frame look straight into the other bank so that
  // back-to-back buffered frames leave no gap.
  always_comb begin
    nxt_bank = rb;
    nxt_idx  = '0;
    nxt_ok   = full[rb];
    if (source_valid) begin
      if (rcnt == LAST) begin
        nxt_bank = ~rb;
        nxt_ok   = full[~rb];
      end else begin
        nxt_idx = rcnt + idx_t'(1);
        nxt_ok  = 1'b1;
      end
    end
    rd_idx  = (BITREV != 0) ? brev(nxt_idx) : nxt_idx;
    rd_word = mem[{nxt_bank, rd_idx}];
    sc_re   = scale(rd_word[2*IW-1:IW]);
    sc_im   = scale(rd_word[IW-1:0]);
  end

  always_comb begin
    set_m = fill_done ? (2'b01 << wb) : 2'b00;
    clr_m = (xfer && rcnt == LAST) ? (2'b01 << rb) : 2'b00;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) full <= 2'b00;
    else         full <= (full | set_m) & ~clr_m;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      rstate     <= R_IDLE;
      rcnt       <= '0;
      rb         <= 1'b0;
      source_sop <= 1'b0;
      source_eop <= 1'b0;
      source_Re  <= '0;
      source_Im  <= '0;
      overflow   <= 1'b0;
    end else if (take) begin
      if (xfer && rcnt == LAST) rb <= ~rb;
      if (nxt_ok) begin
        rstate     <= R_SEND;
        rcnt       <= nxt_idx;
        source_Re  <= sc_re[OW-1:0];
        source_Im  <= sc_im[OW-1:0];
        source_sop <= (nxt_idx == '0);
        source_eop <= (nxt_idx == LAST);
        overflow   <= sc_re[OW] | sc_im[OW];
      end else begin
        rstate     <= R_IDLE;
        source_sop <= 1'b0;
        source_eop <= 1'b0;
        overflow   <= 1'b0;
      end
    end
  end

endmodule
